// File: rtl/dds_pkg.sv
// Shared types and default timing for the DDS parallel-port write scheduler.
package dds_pkg;

  localparam int unsigned ADDR_W = 5;
  localparam int unsigned DATA_W = 8;

  localparam int unsigned DEF_SETUP_CYC  = 2;
  localparam int unsigned DEF_STROBE_CYC = 2;
  localparam int unsigned DEF_HOLD_CYC   = 1;
  localparam int unsigned DEF_UD_CYC     = 4;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_SETUP  = 3'd1,
    ST_STROBE = 3'd2,
    ST_HOLD   = 3'd3,
    ST_WAITN  = 3'd4,
    ST_UPDATE = 3'd5
  } state_e;

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
    logic              last;
  } wr_word_t;

  function automatic int unsigned max4(input int unsigned a, input int unsigned b,
                                       input int unsigned c, input int unsigned d);
    int unsigned m;
    m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    if (d > m) m = d;
    return m;
  endfunction

endpackage

// File: rtl/dds_rr_pick.sv
// Two-requester round-robin picker; prio_i=0 means R0 holds priority and yields on contention.
module dds_rr_pick (
  input  logic [1:0] reqs_i,
  input  logic       prio_i,
  output logic [1:0] pick_c
);

  always_comb begin
    pick_c = 2'b00;
    case (reqs_i)
      2'b01:   pick_c = 2'b01;
      2'b10:   pick_c = 2'b10;
      2'b11:   pick_c = prio_i ? 2'b01 : 2'b10;
      default: pick_c = 2'b00;
    endcase
  end

endmodule

// File: rtl/dds_port_sched.sv
// Arbitrates two register-write requesters onto a DDS parallel port and sequences
// setup / write strobe / hold per word and an IO-update pulse per burst.
module dds_port_sched
  import dds_pkg::*;
#(
  parameter int unsigned SETUP_CYC  = DEF_SETUP_CYC,
  parameter int unsigned STROBE_CYC = DEF_STROBE_CYC,
  parameter int unsigned HOLD_CYC   = DEF_HOLD_CYC,
  parameter int unsigned UD_CYC     = DEF_UD_CYC
) (
  input  logic              CLK,
  input  logic              RSTN,
  input  logic              R0_REQ,
  input  logic [ADDR_W-1:0] R0_ADDR,
  input  logic [DATA_W-1:0] R0_DATA,
  input  logic              R0_LAST,
  input  logic              R1_REQ,
  input  logic [ADDR_W-1:0] R1_ADDR,
  input  logic [DATA_W-1:0] R1_DATA,
  input  logic              R1_LAST,
  output logic              R0_ACK,
  output logic              R1_ACK,
  output logic [1:0]        GRANT,
  output logic [ADDR_W-1:0] DDS_A,
  output logic [DATA_W-1:0] DDS_D,
  output logic              DDS_WRN,
  output logic              DDS_UDCLK,
  output logic              BUSY
);

  localparam int unsigned MAX_CYC = max4(SETUP_CYC, STROBE_CYC, HOLD_CYC, UD_CYC);
  localparam int unsigned CNT_W   = $clog2(MAX_CYC) + 1;

  state_e            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] dat_q, dat_d;
  logic              last_q, last_d;
  logic [1:0]        grant_q, grant_d;
  logic              prio_q, prio_d;
  logic [1:0]        ack_q, ack_d;
  logic              wrn_q, wrn_d;
  logic              ud_q, ud_d;
  logic              busy_q, busy_d;

  logic [1:0]        pick_c;
  logic [1:0]        cap_sel_c;
  wr_word_t          w0_c, w1_c, cap_word_c;

  assign w0_c       = {R0_ADDR, R0_DATA, R0_LAST};
  assign w1_c       = {R1_ADDR, R1_DATA, R1_LAST};
  assign cap_word_c = cap_sel_c[0] ? w0_c : w1_c;

  dds_rr_pick u_pick (
    .reqs_i ({R1_REQ, R0_REQ}),
    .prio_i (prio_q),
    .pick_c (pick_c)
  );

  // State and output registers
  always_ff @(posedge CLK) begin
    if (!RSTN) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      addr_q  <= '0;
      dat_q   <= '0;
      last_q  <= 1'b0;
      grant_q <= 2'b00;
      prio_q  <= 1'b0;
      ack_q   <= 2'b00;
      wrn_q   <= 1'b1;
      ud_q    <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      addr_q  <= addr_d;
      dat_q   <= dat_d;
      last_q  <= last_d;
      grant_q <= grant_d;
      prio_q  <= prio_d;
      ack_q   <= ack_d;
      wrn_q   <= wrn_d;
      ud_q    <= ud_d;
      busy_q  <= busy_d;
    end
  end

  // Next-state logic; port outputs are decoded from the next state so they register with it
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    addr_d    = addr_q;
    dat_d     = dat_q;
    last_d    = last_q;
    grant_d   = grant_q;
    prio_d    = prio_q;
    ack_d     = 2'b00;
    cap_sel_c = 2'b00;

    case (state_q)
      ST_IDLE: cap_sel_c = pick_c;
      ST_SETUP: begin
        if (cnt_q == '0) begin
          state_d = ST_STROBE;
          cnt_d   = CNT_W'(STROBE_CYC - 32'd1);
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      ST_STROBE: begin
        if (cnt_q == '0) begin
          state_d = ST_HOLD;
          cnt_d   = CNT_W'(HOLD_CYC - 32'd1);
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      ST_HOLD: begin
        if (cnt_q == '0) begin
          if (last_q) begin
            state_d = ST_UPDATE;
            cnt_d   = CNT_W'(UD_CYC - 32'd1);
            addr_d  = '0;
            dat_d   = '0;
          end else begin
            state_d = ST_WAITN;
          end
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      // Burst lock: only the current owner can continue; the other side waits
      ST_WAITN: cap_sel_c = grant_q & {R1_REQ, R0_REQ};
      ST_UPDATE: begin
        if (cnt_q == '0) begin
          state_d = ST_IDLE;
          grant_d = 2'b00;
          prio_d  = ~prio_q;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      default: state_d = ST_IDLE;
    endcase

    if (cap_sel_c != 2'b00) begin
      state_d = ST_SETUP;
      cnt_d   = CNT_W'(SETUP_CYC - 32'd1);
      addr_d  = cap_word_c.addr;
      dat_d   = cap_word_c.data;
      last_d  = cap_word_c.last;
      grant_d = cap_sel_c;
      ack_d   = cap_sel_c;
    end

    wrn_d  = (state_d != ST_STROBE);
    ud_d   = (state_d == ST_UPDATE);
    busy_d = (state_d != ST_IDLE);
  end

  assign R0_ACK    = ack_q[0];
  assign R1_ACK    = ack_q[1];
  assign GRANT     = grant_q;
  assign DDS_A     = addr_q;
  assign DDS_D     = dat_q;
  assign DDS_WRN   = wrn_q;
  assign DDS_UDCLK = ud_q;
  assign BUSY      = busy_q;

endmodule

// File: tb/tb_dds_port_sched.sv
// Directed bench for dds_port_sched: per-cycle traces compared against hand-derived waveforms.
module tb_dds_port_sched;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rstn;
  logic       r0_req, r0_last, r1_req, r1_last;
  logic [4:0] r0_addr, r1_addr;
  logic [7:0] r0_data, r1_data;
  logic       r0_ack, r1_ack;
  logic [1:0] grant;
  logic [4:0] dds_a;
  logic [7:0] dds_d;
  logic       wrn, ud, busy;

  logic       b_r0_req, b_r0_last;
  logic [4:0] b_r0_addr;
  logic [7:0] b_r0_data;
  logic       b_r1_req, b_r1_last;
  logic [4:0] b_r1_addr;
  logic [7:0] b_r1_data;
  logic       b_r0_ack, b_r1_ack;
  logic [1:0] b_grant;
  logic [4:0] b_a;
  logic [7:0] b_d;
  logic       b_wrn, b_ud, b_busy;

  dds_port_sched u_dut (
    .CLK(clk), .RSTN(rstn),
    .R0_REQ(r0_req), .R0_ADDR(r0_addr), .R0_DATA(r0_data), .R0_LAST(r0_last),
    .R1_REQ(r1_req), .R1_ADDR(r1_addr), .R1_DATA(r1_data), .R1_LAST(r1_last),
    .R0_ACK(r0_ack), .R1_ACK(r1_ack), .GRANT(grant), .DDS_A(dds_a), .DDS_D(dds_d),
    .DDS_WRN(wrn), .DDS_UDCLK(ud), .BUSY(busy)
  );

  dds_port_sched #(.SETUP_CYC(1), .STROBE_CYC(4), .HOLD_CYC(2)) u_dut_b (
    .CLK(clk), .RSTN(rstn),
    .R0_REQ(b_r0_req), .R0_ADDR(b_r0_addr), .R0_DATA(b_r0_data), .R0_LAST(b_r0_last),
    .R1_REQ(b_r1_req), .R1_ADDR(b_r1_addr), .R1_DATA(b_r1_data), .R1_LAST(b_r1_last),
    .R0_ACK(b_r0_ack), .R1_ACK(b_r1_ack), .GRANT(b_grant), .DDS_A(b_a), .DDS_D(b_d),
    .DDS_WRN(b_wrn), .DDS_UDCLK(b_ud), .BUSY(b_busy)
  );

  int total = 0;
  int bad   = 0;
  int viol  = 0;

  // Traces: bit k holds the value sampled just after edge k of the current window
  logic [63:0] wrn_tr, ud_tr, ack0_tr, ack1_tr, busy_tr, bw_tr, bu_tr;
  int          tk;
  logic        prev_wrn = 1'b1;
  logic [14:0] log_q[$];

  // Requester models: word = {addr, data, last}
  logic [13:0] r0_w[3], r1_w[3];
  int          r0_n, r0_i, r1_n, r1_i;
  logic        r0_drop, r1_drop;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [14:0] log_at(input int i);
    if (log_q.size() > i) return log_q[i];
    return '1;
  endfunction

  task automatic clr();
    wrn_tr = '0; ud_tr = '0; ack0_tr = '0; ack1_tr = '0; busy_tr = '0;
    bw_tr = '0; bu_tr = '0; tk = 0;
  endtask

  task automatic load_r0(input logic [13:0] w0, input logic [13:0] w1,
                         input logic [13:0] w2, input int n);
    r0_w[0] = w0; r0_w[1] = w1; r0_w[2] = w2; r0_n = n; r0_i = 0; r0_drop = 1'b0;
    {r0_addr, r0_data, r0_last} = r0_w[0];
    r0_req = 1'b1;
  endtask

  task automatic load_r1(input logic [13:0] w0, input logic [13:0] w1,
                         input logic [13:0] w2, input int n);
    r1_w[0] = w0; r1_w[1] = w1; r1_w[2] = w2; r1_n = n; r1_i = 0; r1_drop = 1'b0;
    {r1_addr, r1_data, r1_last} = r1_w[0];
    r1_req = 1'b1;
  endtask

  // One clock: sample, log strobe falls, then let requesters react to ACK.
  // A finished requester lingers with REQ high for one extra cycle.
  task automatic step();
    @(posedge clk);
    #1;
    wrn_tr[tk] = wrn; ud_tr[tk] = ud; ack0_tr[tk] = r0_ack; ack1_tr[tk] = r1_ack;
    busy_tr[tk] = busy; bw_tr[tk] = b_wrn; bu_tr[tk] = b_ud;
    if (r0_ack && r1_ack) viol++;
    if (r0_ack && grant != 2'b01) viol++;
    if (r1_ack && grant != 2'b10) viol++;
    if (prev_wrn && !wrn) log_q.push_back({grant, dds_a, dds_d});
    prev_wrn = wrn;
    if (tk < 63) tk++;
    if (r0_drop) begin r0_req = 1'b0; r0_drop = 1'b0; end
    else if (r0_ack) begin
      r0_i++;
      if (r0_i < r0_n) {r0_addr, r0_data, r0_last} = r0_w[r0_i];
      else r0_drop = 1'b1;
    end
    if (r1_drop) begin r1_req = 1'b0; r1_drop = 1'b0; end
    else if (r1_ack) begin
      r1_i++;
      if (r1_i < r1_n) {r1_addr, r1_data, r1_last} = r1_w[r1_i];
      else r1_drop = 1'b1;
    end
  endtask

  task automatic steps(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic do_reset();
    rstn = 1'b0;
    steps(2);
    rstn = 1'b1;
  endtask

  initial begin
    rstn = 1'b0;
    r0_req = 1'b0; r0_addr = '0; r0_data = '0; r0_last = 1'b0;
    r1_req = 1'b0; r1_addr = '0; r1_data = '0; r1_last = 1'b0;
    b_r0_req = 1'b0; b_r0_addr = '0; b_r0_data = '0; b_r0_last = 1'b0;
    b_r1_req = 1'b0; b_r1_addr = '0; b_r1_data = '0; b_r1_last = 1'b0;
    r0_n = 0; r0_i = 0; r1_n = 0; r1_i = 0; r0_drop = 1'b0; r1_drop = 1'b0;
    clr();

    // Reset state
    steps(2);
    chk("rst_out", {grant, dds_a, dds_d, wrn, ud, busy, r0_ack, r1_ack},
        {2'b00, 5'h00, 8'h00, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0});
    chk("rst_b_out", {b_grant, b_a, b_d, b_wrn, b_ud, b_busy},
        {2'b00, 5'h00, 8'h00, 1'b1, 1'b0, 1'b0});
    rstn = 1'b1;

    // Single word from R0
    log_q.delete(); clr();
    load_r0({5'h1F, 8'h20, 1'b1}, '0, '0, 1);
    steps(11);
    chk("w1_wrn",  wrn_tr,  64'h7F3);
    chk("w1_ud",   ud_tr,   64'h1E0);
    chk("w1_ack0", ack0_tr, 64'h1);
    chk("w1_ack1", ack1_tr, 64'h0);
    chk("w1_busy", busy_tr, 64'h1FF);
    chk("w1_logn", 64'(log_q.size()), 64'd1);
    chk("w1_log0", log_at(0), {2'b01, 5'h1F, 8'h20});
    chk("w1_end",  {grant, dds_a, dds_d}, 15'h0);

    // Three-word burst from R1
    log_q.delete(); clr();
    load_r1({5'h09, 8'hAA, 1'b0}, {5'h08, 8'hBB, 1'b0}, {5'h07, 8'hCC, 1'b1}, 3);
    steps(24);
    chk("bu_wrn",  wrn_tr,  64'hFF3CF3);
    chk("bu_ack1", ack1_tr, 64'h1041);
    chk("bu_ud",   ud_tr,   64'h1E0000);
    chk("bu_busy", busy_tr, 64'h1FFFFF);
    chk("bu_logn", 64'(log_q.size()), 64'd3);
    chk("bu_log0", log_at(0), {2'b10, 5'h09, 8'hAA});
    chk("bu_log1", log_at(1), {2'b10, 5'h08, 8'hBB});
    chk("bu_log2", log_at(2), {2'b10, 5'h07, 8'hCC});

    // Contention after reset, then repeat contention
    do_reset();
    log_q.delete(); clr();
    load_r0({5'h01, 8'h11, 1'b1}, '0, '0, 1);
    load_r1({5'h02, 8'h22, 1'b1}, '0, '0, 1);
    steps(20);
    chk("ct_ack0", ack0_tr, 64'h400);
    chk("ct_ack1", ack1_tr, 64'h1);
    load_r0({5'h04, 8'h44, 1'b1}, '0, '0, 1);
    load_r1({5'h03, 8'h33, 1'b1}, '0, '0, 1);
    steps(20);
    chk("ct_logn", 64'(log_q.size()), 64'd4);
    chk("ct_log0", log_at(0), {2'b10, 5'h02, 8'h22});
    chk("ct_log1", log_at(1), {2'b01, 5'h01, 8'h11});
    chk("ct_log2", log_at(2), {2'b10, 5'h03, 8'h33});
    chk("ct_log3", log_at(3), {2'b01, 5'h04, 8'h44});

    // Lock: R0 stalls in WAITN while R1 requests
    do_reset();
    log_q.delete(); clr();
    load_r0({5'h05, 8'h55, 1'b0}, '0, '0, 1);
    step();
    load_r1({5'h07, 8'h77, 1'b1}, '0, '0, 1);
    steps(15);
    chk("lk_hold", {grant, busy, wrn, ud}, {2'b01, 1'b1, 1'b1, 1'b0});
    chk("lk_ack1", ack1_tr, 64'h0);
    clr();
    load_r0({5'h06, 8'h66, 1'b1}, '0, '0, 1);
    steps(22);
    chk("lk2_ack0", ack0_tr, 64'h1);
    chk("lk2_ack1", ack1_tr, 64'h400);
    chk("lk_logn", 64'(log_q.size()), 64'd3);
    chk("lk_log0", log_at(0), {2'b01, 5'h05, 8'h55});
    chk("lk_log1", log_at(1), {2'b01, 5'h06, 8'h66});
    chk("lk_log2", log_at(2), {2'b10, 5'h07, 8'h77});

    // Reset in the middle of the strobe
    clr();
    load_r0({5'h0A, 8'h5A, 1'b1}, '0, '0, 1);
    steps(3);
    chk("rs_pre", {wrn, grant}, {1'b0, 2'b01});
    rstn = 1'b0;
    step();
    chk("rs_edge", {wrn, grant, ud, busy}, {1'b1, 2'b00, 1'b0, 1'b0});
    rstn = 1'b1;
    clr();
    steps(8);
    chk("rs_ud",   ud_tr,   64'h0);
    chk("rs_busy", busy_tr, 64'h0);

    // Alternate timing parameters on the second instance
    clr();
    b_r0_addr = 5'h03; b_r0_data = 8'h3C; b_r0_last = 1'b1; b_r0_req = 1'b1;
    step();
    b_r0_req = 1'b0;
    steps(11);
    chk("pb_wrn", bw_tr, 64'hFE1);
    chk("pb_ud",  bu_tr, 64'h780);

    chk("ack_rules", 64'(viol), 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/dds_port_sched.md
DDS_PORT_SCHED -- requirements
Module: dds_port_sched

Interface
REQ-001 SHALL have parameter SETUP_CYC, default 2: cycles address/data are stable before the write strobe falls.
REQ-002 SHALL have parameter STROBE_CYC, default 2: cycles the write strobe is held low.
REQ-003 SHALL have parameter HOLD_CYC, default 1: cycles address/data are held after the strobe rises.
REQ-004 SHALL have parameter UD_CYC, default 4: width in cycles of the update-clock pulse.
REQ-005 SHALL have port CLK  in  1  system clock; all logic on its rising edge.
REQ-006 SHALL have port RSTN  in  1  reset, synchronous and active-low.
REQ-007 SHALL have ports R0_REQ / R1_REQ  in  1  requester n has a register write pending.
REQ-008 SHALL have ports R0_ADDR / R1_ADDR  in  5  target register address of requester n.
REQ-009 SHALL have ports R0_DATA / R1_DATA  in  8  write data of requester n.
REQ-010 SHALL have ports R0_LAST / R1_LAST  in  1  the presented word ends requester n's burst.
REQ-011 SHALL have ports R0_ACK / R1_ACK  out  1  one-cycle pulse: word captured, so present the next one.
REQ-012 SHALL have port GRANT  out  2  one-hot owner of the DDS port; 00 when idle.
REQ-013 SHALL have port DDS_A  out  5  parallel address to the DDS.
REQ-014 SHALL have port DDS_D  out  8  parallel data to the DDS.
REQ-015 SHALL have port DDS_WRN  out  1  active-low write strobe.
REQ-016 SHALL have port DDS_UDCLK  out  1  active-high IO update pulse.
REQ-017 SHALL have port BUSY  out  1  high whenever the state is not IDLE.

Function
REQ-018 SHALL implement the states IDLE, SETUP, STROBE, HOLD, WAITN and UPDATE.
REQ-019 In IDLE, SHALL grant the requester with REQ=1 when only one requests.
REQ-020 If both request, SHALL grant the requester that does not hold priority; priority flips to the other requester after each completed burst, and R0 holds priority after reset.
REQ-021 On a grant or capture edge, SHALL register ADDR/DATA/LAST into DDS_A/DDS_D and an internal last flag, pulse that requester's ACK for exactly one cycle, set GRANT, and enter SETUP.
REQ-022 SHALL keep DDS_WRN=1 for SETUP_CYC cycles in SETUP, 0 for STROBE_CYC cycles in STROBE, and 1 for HOLD_CYC cycles in HOLD.
REQ-023 Per word, SHALL take SETUP_CYC+STROBE_CYC+HOLD_CYC cycles from capture to the end of HOLD.
REQ-024 SHALL keep DDS_A/DDS_D constant from capture until the next capture, or until they are cleared in UPDATE.
REQ-025 After HOLD with last=0, SHALL enter WAITN with the lock held; the owner's REQ=1 captures the next word (REQ-021), and the other requester is ignored.
REQ-026 After HOLD with last=1, SHALL enter UPDATE: DDS_UDCLK=1 for UD_CYC cycles, DDS_A/DDS_D cleared to 0, then IDLE with GRANT=00 and priority flipped.
REQ-027 A requester asserting REQ in the cycle its ACK pulses SHALL NOT be captured twice; capture happens only in IDLE or WAITN.
REQ-028 ACK SHALL never be asserted to a non-owner, and both ACKs SHALL never be high together.
REQ-029 The owner dropping REQ in WAITN SHALL leave the lock held indefinitely; it is the requester's duty to finish with LAST.
REQ-030 SHALL derive parameter-driven cycle counters from a single down-counter of width clog2(max parameter)+1.

Reset
REQ-031 With RSTN=0 at an edge, SHALL set state=IDLE, GRANT=00, DDS_A=0, DDS_D=0, DDS_WRN=1, DDS_UDCLK=0, ACK=0, BUSY=0, priority=R0, counter=0.
REQ-032 Reset mid-strobe SHALL return DDS_WRN to 1 on that edge, abandon the burst, and issue no update pulse.

Structure
REQ-033 SHALL place the state encoding and the default timing constants in the shared package dds_pkg.
REQ-034 SHALL contain one sub-module, dds_rr_pick: a two-requester round-robin picker (inputs: reqs, priority; output: one-hot pick).

Verification
REQ-035 SHALL test a single word: R0 writes A=1F, D=20, LAST=1 -> ACK 1 cycle; WRN low cycles 3-4 after capture; UDCLK high 4 cycles; word total 5 cycles.
REQ-036 SHALL test a burst: R1 writes 3 words (09/AA, 08/BB, 07/CC, LAST on the third) -> three WRN pulses in order and exactly one UDCLK pulse, after the third.
REQ-037 SHALL test contention: R0 and R1 request in the same cycle after reset -> R1 is served first (R0 holds priority), then R0; a repeat contention serves R1 again.
REQ-038 SHALL test lock: R0 in WAITN while R1 requests -> R1 is not granted until R0's LAST word's UPDATE completes.
REQ-039 SHALL test reset during STROBE -> on the next edge WRN=1, GRANT=00, UDCLK=0, BUSY=0.
REQ-040 SHALL test parameters SETUP_CYC=1, STROBE_CYC=4, HOLD_CYC=2 -> WRN low for exactly 4 cycles and 7 cycles per word.
